pc_sequencer: RTL and testbench

- Registered program-counter unit that replaces the combinational next-PC adder.
- Holds the PC and selects each cycle's next PC from one of: sequential, conditional branch, relative jump, call, return, or register jump.
- Adds a parametrised return-address stack (RAS), pipeline stall hold, and a registered redirect flag for fetch-stage flush.
- Sits between decode/ALU flag outputs and instruction-memory address input.

---
 rtl/pc_sequencer_if.sv | 45 ++++
 rtl/pc_sequencer.sv | 143 ++++++++++++++
 tb/tb_pc_sequencer.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// Command/status bundle between decode/ALU flags and the PC sequencer.
// Master drives the commands; the sequencer (slave) returns PC and RAS status.
interface pc_sequencer_if #(
  parameter int PC_W      = 16,
  parameter int JIMM_W    = 6,
  parameter int BIMM_W    = 3,
  parameter int RAS_DEPTH = 4
);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  logic              stall;
  logic              branch;
  logic              beq;
  logic              is_zero;
  logic              jump;
  logic              call;
  logic              ret;
  logic              jr;
  logic [PC_W-1:0]   rs;
  logic [JIMM_W-1:0] jimm;
  logic [BIMM_W-1:0] bimm;

  logic [PC_W-1:0]   pc;
  logic [PC_W-1:0]   pc_plus1;
  logic              redirect;
  logic [CNT_W-1:0]  ras_count;
  logic              ras_overflow;
  logic              ras_underflow;

  modport master (
    output stall, branch, beq, is_zero,
    output jump, call, ret, jr,
    output rs, jimm, bimm,
    input  pc, pc_plus1, redirect,
    input  ras_count, ras_overflow, ras_underflow
  );

  modport slave (
    input  stall, branch, beq, is_zero,
    input  jump, call, ret, jr,
    input  rs, jimm, bimm,
    output pc, pc_plus1, redirect,
    output ras_count, ras_overflow, ras_underflow
  );
endinterface

// File: rtl/pc_sequencer.sv
// Registered program counter with branch/jump/call/return/jr selection,
// a circular return-address stack and a registered fetch redirect flag.
module pc_sequencer #(
  parameter int              PC_W      = 16,
  parameter int              JIMM_W    = 6,
  parameter int              BIMM_W    = 3,
  parameter int              RAS_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_PC  = '0
) (
  input  logic clk,
  input  logic rst_n,
  pc_sequencer_if.slave bus
);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(RAS_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

  logic [PC_W-1:0]  pc_q;
  logic             redir_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ovf_q;
  logic             unf_q;
  logic [PTR_W-1:0] ptr_q;
  logic [PC_W-1:0]  ras_mem [RAS_DEPTH];

  logic [PC_W-1:0]  pc_inc;
  logic [PC_W-1:0]  jext;
  logic [PC_W-1:0]  bext;
  logic [PTR_W-1:0] top_ptr;
  logic [PTR_W-1:0] nxt_ptr;
  logic             ras_full;
  logic             ras_empty;
  logic             br_taken;

  logic sel_jr;
  logic sel_ret;
  logic sel_call;
  logic sel_jmp;
  logic sel_br;

  logic [PC_W-1:0] pc_nxt;
  logic            redir_nxt;
  logic            push;
  logic            pop;
  logic            ovf_nxt;
  logic            unf_nxt;

  assign pc_inc = pc_q + PC_W'(1);
  assign jext   = {{(PC_W-JIMM_W){bus.jimm[JIMM_W-1]}}, bus.jimm};
  assign bext   = {{(PC_W-BIMM_W){bus.bimm[BIMM_W-1]}}, bus.bimm};

  assign ras_full  = (cnt_q == CNT_MAX);
  assign ras_empty = (cnt_q == '0);
  assign top_ptr   = (ptr_q == '0) ? PTR_MAX : ptr_q - PTR_W'(1);
  assign nxt_ptr   = (ptr_q == PTR_MAX) ? '0 : ptr_q + PTR_W'(1);

  assign br_taken = bus.branch &
                    (bus.beq ? bus.is_zero : ~bus.is_zero);

  // Mutually exclusive selects so the decoder below can be unique.
  assign sel_jr   = ~bus.stall & bus.jr;
  assign sel_ret  = ~bus.stall & ~bus.jr & bus.ret;
  assign sel_call = ~bus.stall & ~bus.jr & ~bus.ret & bus.call;
  assign sel_jmp  = ~bus.stall & ~bus.jr & ~bus.ret
                  & ~bus.call & bus.jump;
  assign sel_br   = ~bus.stall & ~bus.jr & ~bus.ret
                  & ~bus.call & ~bus.jump & br_taken;

  always_comb begin
    pc_nxt    = bus.stall ? pc_q : pc_inc;
    redir_nxt = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    ovf_nxt   = 1'b0;
    unf_nxt   = 1'b0;
    unique case (1'b1)
      sel_jr: begin
        pc_nxt    = bus.rs;
        redir_nxt = 1'b1;
      end
      sel_ret: begin
        if (ras_empty) begin
          unf_nxt = 1'b1;
        end else begin
          pc_nxt    = ras_mem[top_ptr];
          pop       = 1'b1;
          redir_nxt = 1'b1;
        end
      end
      sel_call: begin
        pc_nxt    = pc_inc + jext;
        push      = 1'b1;
        ovf_nxt   = ras_full;
        redir_nxt = 1'b1;
      end
      sel_jmp: begin
        pc_nxt    = pc_inc + jext;
        redir_nxt = 1'b1;
      end
      sel_br: begin
        pc_nxt    = pc_inc + bext;
        redir_nxt = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      redir_q <= 1'b0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      ptr_q   <= '0;
    end else begin
      pc_q    <= pc_nxt;
      redir_q <= redir_nxt;
      ovf_q   <= ovf_nxt;
      unf_q   <= unf_nxt;
      if (push) begin
        ptr_q <= nxt_ptr;
        if (!ras_full) cnt_q <= cnt_q + CNT_W'(1);
      end else if (pop) begin
        ptr_q <= top_ptr;
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

  // Contents are don't-care after reset; the pointer and count gate use.
  always_ff @(posedge clk) begin
    if (push) ras_mem[ptr_q] <= pc_inc;
  end

  assign bus.pc            = pc_q;
  assign bus.pc_plus1      = pc_inc;
  assign bus.redirect      = redir_q;
  assign bus.ras_count     = cnt_q;
  assign bus.ras_overflow  = ovf_q;
  assign bus.ras_underflow = unf_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed vector bench for pc_sequencer: table of per-cycle commands
// with hand-computed PC/RAS results, plus an async reset sequence.
module tb_pc_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  pc_sequencer_if #(
    .PC_W(16), .JIMM_W(6), .BIMM_W(3), .RAS_DEPTH(4)
  ) bus ();

  pc_sequencer #(
    .PC_W(16), .JIMM_W(6), .BIMM_W(3),
    .RAS_DEPTH(4), .RESET_PC(16'h0000)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  localparam logic [7:0] S  = 8'h80;
  localparam logic [7:0] BR = 8'h40;
  localparam logic [7:0] EQ = 8'h20;
  localparam logic [7:0] Z  = 8'h10;
  localparam logic [7:0] J  = 8'h08;
  localparam logic [7:0] CL = 8'h04;
  localparam logic [7:0] RT = 8'h02;
  localparam logic [7:0] JR = 8'h01;
  localparam logic [7:0] NO = 8'h00;

  typedef struct {
    logic [7:0]  cmd;
    logic [15:0] rs;
    logic [5:0]  jimm;
    logic [2:0]  bimm;
    logic [15:0] e_pc;
    logic        e_red;
    logic [2:0]  e_cnt;
    logic        e_ovf;
    logic        e_unf;
  } vec_t;

  vec_t tv[$];
  int total = 0;
  int passed = 0;

  function automatic vec_t v(
    input logic [7:0]  cmd,
    input logic [15:0] rs,
    input logic [5:0]  jimm,
    input logic [2:0]  bimm,
    input logic [15:0] e_pc,
    input logic        e_red,
    input logic [2:0]  e_cnt,
    input logic        e_ovf,
    input logic        e_unf
  );
    vec_t r;
    r.cmd = cmd; r.rs = rs; r.jimm = jimm; r.bimm = bimm;
    r.e_pc = e_pc; r.e_red = e_red; r.e_cnt = e_cnt;
    r.e_ovf = e_ovf; r.e_unf = e_unf;
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic drive(input logic [7:0] cmd, input logic [15:0] rs,
                       input logic [5:0] jimm, input logic [2:0] bimm);
    bus.stall   = cmd[7];
    bus.branch  = cmd[6];
    bus.beq     = cmd[5];
    bus.is_zero = cmd[4];
    bus.jump    = cmd[3];
    bus.call    = cmd[2];
    bus.ret     = cmd[1];
    bus.jr      = cmd[0];
    bus.rs      = rs;
    bus.jimm    = jimm;
    bus.bimm    = bimm;
  endtask

  task automatic chk_all(input string tag, input logic [15:0] e_pc,
                         input logic e_red, input logic [2:0] e_cnt,
                         input logic e_ovf, input logic e_unf);
    logic [15:0] e_p1;
    e_p1 = e_pc + 16'd1;
    chk({tag, ".pc"}, int'(bus.pc), int'(e_pc));
    chk({tag, ".pc_plus1"}, int'(bus.pc_plus1), int'(e_p1));
    chk({tag, ".redirect"}, int'(bus.redirect), int'(e_red));
    chk({tag, ".ras_count"}, int'(bus.ras_count), int'(e_cnt));
    chk({tag, ".ras_overflow"}, int'(bus.ras_overflow), int'(e_ovf));
    chk({tag, ".ras_underflow"}, int'(bus.ras_underflow), int'(e_unf));
  endtask

  initial begin
    drive(NO, 16'h0, 6'h0, 3'h0);

    // sequential from reset
    tv.push_back(v(NO, 16'h0000, 6'd0, 3'd0, 16'h0001, 0, 0, 0, 0));
    tv.push_back(v(NO, 16'h0000, 6'd0, 3'd0, 16'h0002, 0, 0, 0, 0));
    tv.push_back(v(NO, 16'h0000, 6'd0, 3'd0, 16'h0003, 0, 0, 0, 0));
    // branches
    tv.push_back(v(JR, 16'h0010, 6'd0, 3'd0, 16'h0010, 1, 0, 0, 0));
    tv.push_back(v(BR|EQ|Z, 16'h0, 6'd0, 3'b101, 16'h000E, 1, 0, 0, 0));
    tv.push_back(v(JR, 16'h0010, 6'd0, 3'd0, 16'h0010, 1, 0, 0, 0));
    tv.push_back(v(BR|EQ, 16'h0, 6'd0, 3'b101, 16'h0011, 0, 0, 0, 0));
    tv.push_back(v(BR, 16'h0, 6'd0, 3'b010, 16'h0014, 1, 0, 0, 0));
    // jump, jr priority, negative jump
    tv.push_back(v(JR, 16'h0020, 6'd0, 3'd0, 16'h0020, 1, 0, 0, 0));
    tv.push_back(v(J, 16'h0, 6'b011111, 3'd0, 16'h0040, 1, 0, 0, 0));
    tv.push_back(v(JR|J, 16'h1234, 6'd5, 3'd0, 16'h1234, 1, 0, 0, 0));
    tv.push_back(v(J, 16'h0, 6'b100000, 3'd0, 16'h1215, 1, 0, 0, 0));
    // call/return nesting
    tv.push_back(v(JR, 16'h0100, 6'd0, 3'd0, 16'h0100, 1, 0, 0, 0));
    tv.push_back(v(CL, 16'h0, 6'd4, 3'd0, 16'h0105, 1, 1, 0, 0));
    tv.push_back(v(CL, 16'h0, 6'd2, 3'd0, 16'h0108, 1, 2, 0, 0));
    tv.push_back(v(RT|CL, 16'h0, 6'd9, 3'd0, 16'h0106, 1, 1, 0, 0));
    tv.push_back(v(RT, 16'h0, 6'd0, 3'd0, 16'h0101, 1, 0, 0, 0));
    tv.push_back(v(RT, 16'h0, 6'd0, 3'd0, 16'h0102, 0, 0, 0, 1));
    tv.push_back(v(NO, 16'h0, 6'd0, 3'd0, 16'h0103, 0, 0, 0, 0));
    // RAS overflow / LIFO / underflow
    tv.push_back(v(JR, 16'h0200, 6'd0, 3'd0, 16'h0200, 1, 0, 0, 0));
    tv.push_back(v(CL, 16'h0, 6'd0, 3'd0, 16'h0201, 1, 1, 0, 0));
    tv.push_back(v(CL, 16'h0, 6'd0, 3'd0, 16'h0202, 1, 2, 0, 0));
    tv.push_back(v(CL, 16'h0, 6'd0, 3'd0, 16'h0203, 1, 3, 0, 0));
    tv.push_back(v(CL, 16'h0, 6'd0, 3'd0, 16'h0204, 1, 4, 0, 0));
    tv.push_back(v(CL, 16'h0, 6'd0, 3'd0, 16'h0205, 1, 4, 1, 0));
    tv.push_back(v(NO, 16'h0, 6'd0, 3'd0, 16'h0206, 0, 4, 0, 0));
    tv.push_back(v(RT, 16'h0, 6'd0, 3'd0, 16'h0205, 1, 3, 0, 0));
    tv.push_back(v(RT, 16'h0, 6'd0, 3'd0, 16'h0204, 1, 2, 0, 0));
    tv.push_back(v(RT, 16'h0, 6'd0, 3'd0, 16'h0203, 1, 1, 0, 0));
    tv.push_back(v(RT, 16'h0, 6'd0, 3'd0, 16'h0202, 1, 0, 0, 0));
    tv.push_back(v(RT, 16'h0, 6'd0, 3'd0, 16'h0203, 0, 0, 0, 1));
    // stall holds and clears pulses
    tv.push_back(v(J, 16'h0, 6'd1, 3'd0, 16'h0205, 1, 0, 0, 0));
    tv.push_back(v(S|J, 16'h0, 6'd1, 3'd0, 16'h0205, 0, 0, 0, 0));
    tv.push_back(v(S|J, 16'h0, 6'd1, 3'd0, 16'h0205, 0, 0, 0, 0));
    tv.push_back(v(S|CL, 16'h0, 6'd3, 3'd0, 16'h0205, 0, 0, 0, 0));
    tv.push_back(v(S|RT, 16'h0, 6'd0, 3'd0, 16'h0205, 0, 0, 0, 0));
    // wrap-around
    tv.push_back(v(JR, 16'hFFFF, 6'd0, 3'd0, 16'hFFFF, 1, 0, 0, 0));
    tv.push_back(v(NO, 16'h0, 6'd0, 3'd0, 16'h0000, 0, 0, 0, 0));
    tv.push_back(v(J, 16'h0, 6'b111111, 3'd0, 16'h0000, 1, 0, 0, 0));
    tv.push_back(v(BR|EQ|Z, 16'h0, 6'd0, 3'b100, 16'hFFFD, 1, 0, 0, 0));

    // reset state, asynchronous and held across edges
    #1;
    chk_all("rst0", 16'h0000, 0, 0, 0, 0);
    @(posedge clk); #1;
    chk_all("rst1", 16'h0000, 0, 0, 0, 0);
    rst_n = 1'b1;

    foreach (tv[i]) begin
      drive(tv[i].cmd, tv[i].rs, tv[i].jimm, tv[i].bimm);
      @(posedge clk); #1;
      chk_all($sformatf("v%0d", i), tv[i].e_pc, tv[i].e_red,
              tv[i].e_cnt, tv[i].e_ovf, tv[i].e_unf);
    end

    // async reset between edges aborts an in-flight call
    drive(CL, 16'h0, 6'd0, 3'd0);
    @(posedge clk); #1;
    chk_all("pre_arst", 16'hFFFE, 1, 1, 0, 0);
    #3;
    rst_n = 1'b0;
    #1;
    chk_all("arst_now", 16'h0000, 0, 0, 0, 0);
    @(posedge clk); #1;
    chk_all("arst_edge", 16'h0000, 0, 0, 0, 0);
    rst_n = 1'b1;
    drive(NO, 16'h0, 6'd0, 3'd0);
    @(posedge clk); #1;
    chk_all("post_arst", 16'h0001, 0, 0, 0, 0);
    drive(RT, 16'h0, 6'd0, 3'd0);
    @(posedge clk); #1;
    chk_all("post_arst_ret", 16'h0002, 0, 0, 0, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
